updi_double_break: RTL
======================

UPDI_DOUBLE_BREAK -- requirements
Module: updi_double_break

Interface
REQ-001 SHALL have parameter BREAK_CLKS, default 1250000, the number of clk cycles each break holds the line low (25 ms at 50 MHz).
REQ-002 SHALL have parameter GAP_CLKS, default 50000, the number of clk cycles the line is released after each break.
REQ-003 SHALL have parameter CNT_BITS, default $clog2(max(BREAK_CLKS,GAP_CLKS))+1, the width of the down-counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a request to begin a double break, sampled in IDLE.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-009 SHALL have port updi_low, output, 1 bit: when 1, forces the UPDI pad low, overriding the UART TX.
REQ-010 SHALL have port uart_hold, output, 1 bit: when 1, the UART PHY SHALL NOT start a new TX byte.
REQ-011 SHALL have port uart_tx_idle, input, 1 bit: the UART shifter and TX FIFO are empty.
REQ-012 SHALL have port uart_rx_fifo_empty, input, 1 bit: the UART RX FIFO empty flag.
REQ-013 SHALL have port uart_rx_fifo_rd_en, output, 1 bit: the RX FIFO pop strobe.

Function
REQ-014 SHALL implement the states IDLE, WAIT_TX, BREAK1, GAP1, BREAK2, GAP2, FLUSH and DONE.
REQ-015 SHALL go from IDLE to WAIT_TX on start=1; start SHALL be ignored in all other states, with no queuing.
REQ-016 SHALL assert uart_hold in WAIT_TX and leave WAIT_TX for BREAK1 on the first cycle with uart_tx_idle=1.
REQ-017 SHALL load the counter with BREAK_CLKS-1 on entry to BREAK1/BREAK2 and with GAP_CLKS-1 on entry to GAP1/GAP2, and decrement it each cycle.
REQ-018 SHALL transition out of a BREAK/GAP state in the cycle the counter reads 0, so each state lasts exactly its parameter count of cycles.
REQ-019 SHALL follow the order BREAK1 -> GAP1 -> BREAK2 -> GAP2.
REQ-020 SHALL go from GAP2 to FLUSH when the macro is defined, and to DONE otherwise.
REQ-021 SHALL drive updi_low=1 only in BREAK1 and BREAK2, and uart_hold=1 in every non-IDLE state.
REQ-022 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE; busy SHALL be 1 during DONE and 0 the cycle after.
REQ-023 SHALL assert uart_rx_fifo_rd_en combinationally as (state==FLUSH && !uart_rx_fifo_empty); it SHALL be 0 in all other states.
REQ-024 SHALL leave FLUSH for DONE on the first cycle in FLUSH with uart_rx_fifo_empty=1, popping nothing that cycle.
REQ-025 SHALL register every output except uart_rx_fifo_rd_en; busy, updi_low, uart_hold and done SHALL be functions of the registered state only.
REQ-026 SHALL support BREAK_CLKS=1 or GAP_CLKS=1, with the state held for one cycle; values of 0 are illegal and SHALL trigger an elaboration-time $error.
REQ-027 SHALL NOT require uart_tx_idle after WAIT_TX; its changes after that state SHALL be ignored.

Reset
REQ-028 SHALL, while rst=0, immediately force state=IDLE, counter=0, busy=0, done=0, updi_low=0, uart_hold=0 and uart_rx_fifo_rd_en=0.
REQ-029 SHALL, on reset mid-break, release updi_low asynchronously and produce no done pulse.
REQ-030 SHALL accept start on the first posedge after rst deasserts.

Configuration
REQ-031 SHALL, with UPDI_DB_RX_FLUSH_EN defined, include the FLUSH state, draining RX bytes echoed or garbled by the breaks before done.
REQ-032 SHALL, without UPDI_DB_RX_FLUSH_EN, omit FLUSH, tie uart_rx_fifo_rd_en to 0, ignore uart_rx_fifo_empty, and go GAP2 -> DONE.

Verification
REQ-033 SHALL cover basic timing: BREAK_CLKS=10, GAP_CLKS=3, uart_tx_idle=1, one start pulse -> updi_low high 10 cycles, low 3, high 10, low 3; done one cycle after GAP2 (no macro); busy high 28 cycles total (1 WAIT_TX + 26 + 1 DONE).
REQ-034 SHALL cover a TX-busy hold-off: uart_tx_idle=0 for 5 cycles after start -> updi_low stays 0 and uart_hold 1 for those 5 cycles, and BREAK1 starts the cycle after uart_tx_idle rises.
REQ-035 SHALL cover the flush with macro defined: RX FIFO holding 3 bytes at GAP2 exit -> exactly 3 rd_en pulses, then done, and the FIFO is empty.
REQ-036 SHALL cover reset mid-break: rst=0 at cycle 5 of BREAK2 -> updi_low=0 and busy=0 in the same cycle without waiting for a clock edge, and no done pulse follows.
REQ-037 SHALL cover restart and ignored start: start held high continuously -> start is ignored while busy, and a new sequence begins the cycle after busy drops.
REQ-038 SHALL cover minimum parameters: BREAK_CLKS=1, GAP_CLKS=1 -> updi_low pattern 1,0,1,0 on consecutive cycles.

Source files
------------

// File: rtl/updi_double_break.sv
// UPDI double-break generator: holds the pad low for two breaks separated by gaps, with UART hold-off.
// Optional RX drain after the second gap is enabled by defining UPDI_DB_RX_FLUSH_EN.
module updi_double_break #(
    parameter int BREAK_CLKS = 1250000,
    parameter int GAP_CLKS   = 50000,
    parameter int CNT_BITS   = $clog2((BREAK_CLKS > GAP_CLKS) ? BREAK_CLKS : GAP_CLKS) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic updi_low,
    output logic uart_hold,
    input  logic uart_tx_idle,
    input  logic uart_rx_fifo_empty,
    output logic uart_rx_fifo_rd_en
);

    // state   | meaning
    // IDLE    | waiting for start
    // WAIT_TX | UART held, waiting for TX to drain
    // BREAK1  | pad forced low, first break
    // GAP1    | pad released between breaks
    // BREAK2  | pad forced low, second break
    // GAP2    | pad released after second break
    // FLUSH   | popping RX bytes echoed/garbled by the breaks
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE, WAIT_TX, BREAK1, GAP1, BREAK2, GAP2, FLUSH, DONE
    } state_t;

    if (BREAK_CLKS < 1 || GAP_CLKS < 1) begin : g_param_check
        $error("updi_double_break: BREAK_CLKS and GAP_CLKS must be at least 1");
    end

    localparam logic [CNT_BITS-1:0] BREAK_LOAD = CNT_BITS'(BREAK_CLKS - 1);
    localparam logic [CNT_BITS-1:0] GAP_LOAD   = CNT_BITS'(GAP_CLKS - 1);

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] cnt, cnt_nxt;
    logic                cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (uart_tx_idle) begin
                    state_nxt = BREAK1;
                    cnt_nxt   = BREAK_LOAD;
                end
            end
            BREAK1: begin
                if (cnt_zero) begin
                    state_nxt = GAP1;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP1: begin
                if (cnt_zero) begin
                    state_nxt = BREAK2;
                    cnt_nxt   = BREAK_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            BREAK2: begin
                if (cnt_zero) begin
                    state_nxt = GAP2;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP2: begin
                if (cnt_zero) begin
`ifdef UPDI_DB_RX_FLUSH_EN
                    state_nxt = FLUSH;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`ifdef UPDI_DB_RX_FLUSH_EN
            FLUSH: begin
                if (uart_rx_fifo_empty) state_nxt = DONE;
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are registered copies of the state decode, so they change only with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            uart_hold <= 1'b0;
            updi_low  <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= (state_nxt != IDLE);
            uart_hold <= (state_nxt != IDLE);
            updi_low  <= (state_nxt == BREAK1) || (state_nxt == BREAK2);
            done      <= (state_nxt == DONE);
        end
    end

`ifdef UPDI_DB_RX_FLUSH_EN
    assign uart_rx_fifo_rd_en = (state == FLUSH) && !uart_rx_fifo_empty;
`else
    logic unused_rx_fifo_empty;
    assign unused_rx_fifo_empty = uart_rx_fifo_empty;
    assign uart_rx_fifo_rd_en   = 1'b0;
`endif

endmodule
